adc_trigger_seq: RTL and testbench

Parametrised successor to the single-input ADC start pulser in the FOC datapath. It qualifies a multi-channel "low-side on" window using a runtime channel mask and an all-of/any-of mode. After a runtime-programmable acquisition delay it issues one `start_conv` pulse per window, then supervises the ADC conversion handshake with a timeout. It sits between the PWM/gate-drive block and the ADC interface, and reports overrun, timeout and optional trigger statistics to the control register bank.

---
 rtl/adc_trigger_seq.sv | 183 ++++++++++++++++++
 tb/tb_adc_trigger_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_seq.sv
// adc_trigger_seq: masked multi-phase window qualifier, acquisition delay, one ADC start per window,
// conversion-timeout supervision. Define ADC_TRIG_STATS_EN to build the trigger/abort statistics counters.
`timescale 1ns/1ps
module adc_trigger_seq #(
  parameter int N_CH      = 3,
  parameter int CNT_W     = 8,
  parameter int T_ACQ_DEF = 120,
  parameter int T_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_CH-1:0]  low_on,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             mode_any,
  input  logic [CNT_W-1:0] acq_cycles,
  input  logic             adc_busy,
  input  logic             adc_done,
  input  logic             clr_flags,
  output logic             start_conv,
  output logic             overrun,
  output logic             timeout,
  output logic             conv_active,
  output logic [15:0]      trig_cnt,
  output logic [15:0]      abort_cnt
);

  localparam logic [CNT_W-1:0] ACQ_DEF  = CNT_W'(T_ACQ_DEF);
  localparam logic [15:0]      TMO_LAST = 16'(T_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISARM  = 3'd1,
    S_WAIT_HI = 3'd2,
    S_ACQ     = 3'd3,
    S_CONV    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             start_conv_q, start_conv_d;
  logic             conv_active_q, conv_active_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             overrun_set, timeout_set;

  logic             window;
  logic [CNT_W-1:0] acq_len;
  logic             acq_hit;
  logic             tmo_hit;

  // An empty mask never opens a window, even in all-of mode where the reduction would be vacuously true
  always_comb begin
    window = 1'b0;
    if (ch_mask != '0)
      window = mode_any ? |(low_on & ch_mask) : &(low_on | ~ch_mask);
  end

  assign acq_len = (acq_cycles == '0) ? ACQ_DEF : acq_cycles;
  assign acq_hit = (cnt_q == len_q);
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_DISARM;
        S_DISARM:  if (!window) state_d = S_WAIT_HI;
        S_WAIT_HI: if (window) state_d = S_ACQ;
        S_ACQ: begin
          if (!window)      state_d = S_WAIT_HI;
          else if (acq_hit) state_d = adc_busy ? S_DISARM : S_CONV;
        end
        S_CONV:    if (adc_done || tmo_hit) state_d = S_DISARM;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_conv_d = 1'b0;
    overrun_set  = 1'b0;
    timeout_set  = 1'b0;
    cnt_d        = cnt_q;
    len_d        = len_q;
    tmo_d        = tmo_q;
    if (enable) begin
      case (state_q)
        S_WAIT_HI: begin
          if (window) begin
            cnt_d = CNT_W'(1);
            len_d = acq_len;
          end
        end
        S_ACQ: begin
          if (window) begin
            if (acq_hit) begin
              if (adc_busy) begin
                overrun_set = 1'b1;
              end else begin
                start_conv_d = 1'b1;
                tmo_d        = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_CONV: begin
          tmo_d       = tmo_q + 16'd1;
          timeout_set = !adc_done && tmo_hit;
        end
        default: ;
      endcase
    end
    conv_active_d = (state_d == S_CONV);
    // A flag being set in the same cycle as a clear request survives
    overrun_d     = overrun_set | (overrun_q & ~clr_flags);
    timeout_d     = timeout_set | (timeout_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      len_q         <= '0;
      tmo_q         <= '0;
      start_conv_q  <= 1'b0;
      conv_active_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      tmo_q         <= tmo_d;
      start_conv_q  <= start_conv_d;
      conv_active_q <= conv_active_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign start_conv  = start_conv_q;
  assign conv_active = conv_active_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

`ifdef ADC_TRIG_STATS_EN
  logic [15:0] trig_cnt_q, abort_cnt_q;
  logic        abort_ev;

  assign abort_ev = enable && (state_q == S_ACQ) && !window;

  // Free-running, wrap at 16 bits; an event coinciding with a clear counts as the first after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      trig_cnt_q  <= (clr_flags ? 16'd0 : trig_cnt_q) + {15'd0, start_conv_d};
      abort_cnt_q <= (clr_flags ? 16'd0 : abort_cnt_q) + {15'd0, abort_ev};
    end
  end

  assign trig_cnt  = trig_cnt_q;
  assign abort_cnt = abort_cnt_q;
`else
  assign trig_cnt  = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_trigger_seq.sv
// Self-checking bench for adc_trigger_seq: directed plan steps followed by a randomized run,
// all compared cycle by cycle against a window/age/conversion-time reference model.
`timescale 1ns/1ps
module tb_adc_trigger_seq;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int T_ACQ = 120;
  localparam int T_TMO = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [N_CH-1:0]  low_on;
  logic [N_CH-1:0]  ch_mask;
  logic             mode_any;
  logic [CNT_W-1:0] acq_cycles;
  logic             adc_busy;
  logic             adc_done;
  logic             clr_flags;
  logic             start_conv;
  logic             overrun;
  logic             timeout;
  logic             conv_active;
  logic [15:0]      trig_cnt;
  logic [15:0]      abort_cnt;

  adc_trigger_seq #(
    .N_CH(N_CH), .CNT_W(CNT_W), .T_ACQ_DEF(T_ACQ), .T_TIMEOUT(T_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .low_on(low_on), .ch_mask(ch_mask),
    .mode_any(mode_any), .acq_cycles(acq_cycles), .adc_busy(adc_busy), .adc_done(adc_done),
    .clr_flags(clr_flags), .start_conv(start_conv), .overrun(overrun), .timeout(timeout),
    .conv_active(conv_active), .trig_cnt(trig_cnt), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: armed-ness, age of the current window, time spent converting
  bit m_idle, m_need_low, m_start, m_ovr, m_tmo;
  int m_age, m_L, m_conv, m_trig, m_abort;

  int step_idx, n_pulse, first_pulse;

  function automatic bit win_model();
    int sel = 0;
    int hi  = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_mask[i]) begin
        sel++;
        if (low_on[i]) hi++;
      end
    end
    if (mode_any) return hi > 0;
    return (sel > 0) && (hi == sel);
  endfunction

  function automatic logic [15:0] stat(input int v);
`ifdef ADC_TRIG_STATS_EN
    return 16'(v);
`else
    return 16'(v & 0);
`endif
  endfunction

  task automatic model_reset();
    m_idle = 1; m_need_low = 0; m_start = 0; m_ovr = 0; m_tmo = 0;
    m_age = -1; m_L = 0; m_conv = -1; m_trig = 0; m_abort = 0;
  endtask

  task automatic model_step();
    bit w, ovr_set, tmo_set;
    int t_inc, a_inc;
    w = win_model();
    ovr_set = 0; tmo_set = 0; t_inc = 0; a_inc = 0;
    m_start = 0;
    if (!enable) begin
      m_idle = 1; m_age = -1; m_conv = -1;
    end else if (m_idle) begin
      m_idle = 0; m_need_low = 1;
    end else if (m_conv >= 0) begin
      m_conv++;
      if (adc_done) begin
        m_conv = -1; m_need_low = 1;
      end else if (m_conv == T_TMO) begin
        tmo_set = 1; m_conv = -1; m_need_low = 1;
      end
    end else if (m_age >= 1) begin
      if (!w) begin
        m_age = -1; a_inc = 1;
      end else if (m_age == m_L) begin
        m_age = -1;
        if (adc_busy) begin
          ovr_set = 1; m_need_low = 1;
        end else begin
          m_start = 1; t_inc = 1; m_conv = 0;
        end
      end else begin
        m_age++;
      end
    end else if (m_need_low) begin
      if (!w) m_need_low = 0;
    end else if (w) begin
      m_age = 1;
      m_L = (acq_cycles == 0) ? T_ACQ : int'(acq_cycles);
    end
    m_ovr   = ovr_set | (m_ovr & !clr_flags);
    m_tmo   = tmo_set | (m_tmo & !clr_flags);
    m_trig  = ((clr_flags ? 0 : m_trig) + t_inc) & 16'hFFFF;
    m_abort = ((clr_flags ? 0 : m_abort) + a_inc) & 16'hFFFF;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("start_conv",  32'(start_conv),  32'(m_start));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("timeout",     32'(timeout),     32'(m_tmo));
    chk("conv_active", 32'(conv_active), 32'(m_conv >= 0));
    chk("trig_cnt",    32'(trig_cnt),    32'(stat(m_trig)));
    chk("abort_cnt",   32'(abort_cnt),   32'(stat(m_abort)));
  endtask

  task automatic mark();
    step_idx = 0; n_pulse = 0; first_pulse = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check_all();
    step_idx++;
    if (start_conv === 1'b1) begin
      n_pulse++;
      if (first_pulse == 0) first_pulse = step_idx;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_done();
    adc_done = 1'b1; step(); adc_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; low_on = '0; ch_mask = 3'b111; mode_any = 1'b0;
    acq_cycles = 8'd10; adc_busy = 1'b0; adc_done = 1'b0; clr_flags = 1'b0;
    model_reset();
    mark();
    #12;
    chk("rst_start_conv",  32'(start_conv),  32'd0);
    chk("rst_overrun",     32'(overrun),     32'd0);
    chk("rst_timeout",     32'(timeout),     32'd0);
    chk("rst_conv_active", 32'(conv_active), 32'd0);
    chk("rst_trig_cnt",    32'(trig_cnt),    32'd0);
    chk("rst_abort_cnt",   32'(abort_cnt),   32'd0);
    rst_n = 1'b1;
    steps(2);

    // Plan 1: all-of window, L=10, done 20 cycles after the pulse
    enable = 1'b1;
    steps(3);
    mark();
    low_on = 3'b111;
    for (int i = 1; i <= 50; i++) begin
      adc_done = (i == 31);
      step();
    end
    adc_done = 1'b0;
    chk("t1_pulses",     32'(n_pulse),         32'd1);
    chk("t1_pulse_edge", 32'(first_pulse - 1), 32'd10);
    chk("t1_overrun",    32'(overrun),         32'd0);
    chk("t1_timeout",    32'(timeout),         32'd0);
    chk("t1_trig_cnt",   32'(trig_cnt),        32'(stat(1)));

    // Plan 2: one channel drops at E5, then the window reopens
    low_on = 3'b000;
    steps(2);
    mark();
    low_on = 3'b111;
    steps(5);
    low_on = 3'b110;
    step();
    chk("t2_abort_pulses", 32'(n_pulse),   32'd0);
    chk("t2_abort_cnt",    32'(abort_cnt), 32'(stat(1)));
    mark();
    low_on = 3'b111;
    steps(12);
    chk("t2_pulse_edge", 32'(first_pulse - 1), 32'd10);
    chk("t2_pulses",     32'(n_pulse),         32'd1);
    pulse_done();

    // Plan 3: default length, any-of with single masked channel, others toggling
    acq_cycles = 8'd0; mode_any = 1'b1; ch_mask = 3'b010; low_on = 3'b000;
    steps(2);
    mark();
    for (int i = 0; i < 130; i++) begin
      low_on = {1'($urandom_range(1)), 1'b1, 1'($urandom_range(1))};
      step();
    end
    chk("t3_pulse_edge", 32'(first_pulse - 1), 32'd120);
    chk("t3_pulses",     32'(n_pulse),         32'd1);
    pulse_done();

    // Plan 4: ADC busy at E_L -> overrun, then clear
    acq_cycles = 8'd5; mode_any = 1'b0; ch_mask = 3'b111; low_on = 3'b000;
    steps(2);
    mark();
    low_on = 3'b111; adc_busy = 1'b1;
    steps(6);
    chk("t4_pulses",  32'(n_pulse), 32'd0);
    chk("t4_overrun", 32'(overrun), 32'd1);
    adc_busy = 1'b0; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // Plan 5: no adc_done -> timeout, then rearm only via a new window
    low_on = 3'b000;
    steps(2);
    mark();
    low_on = 3'b111;
    steps(6);
    chk("t5_pulse_edge", 32'(first_pulse - 1), 32'd5);
    steps(T_TMO - 1);
    chk("t5_timeout_early", 32'(timeout),     32'd0);
    chk("t5_conv_active",   32'(conv_active), 32'd1);
    step();
    chk("t5_timeout",      32'(timeout),     32'd1);
    chk("t5_conv_dropped", 32'(conv_active), 32'd0);
    mark();
    steps(20);
    chk("t5_no_retrigger", 32'(n_pulse), 32'd0);
    low_on = 3'b000;
    steps(2);
    mark();
    low_on = 3'b111;
    steps(6);
    chk("t5_rearm_pulses", 32'(n_pulse), 32'd1);
    pulse_done();

    // Plan 6: enable mid-window, then asynchronous reset mid-acquisition
    enable = 1'b0;
    steps(2);
    low_on = 3'b111; enable = 1'b1;
    mark();
    steps(20);
    chk("t6_enable_mid_window", 32'(n_pulse), 32'd0);
    low_on = 3'b000;
    steps(2);
    low_on = 3'b111;
    steps(3);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_timeout",     32'(timeout),     32'd0);
    chk("t6_rst_start_conv",  32'(start_conv),  32'd0);
    chk("t6_rst_conv_active", 32'(conv_active), 32'd0);
    chk("t6_rst_trig_cnt",    32'(trig_cnt),    32'd0);
    steps(2);
    rst_n = 1'b1;
    mark();
    steps(20);
    chk("t6_post_rst_pulses", 32'(n_pulse), 32'd0);
    low_on = 3'b000;
    steps(2);
    mark();
    low_on = 3'b111;
    steps(6);
    chk("t6_reopen_pulse_edge", 32'(first_pulse - 1), 32'd5);
    pulse_done();

    // Randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(99) != 0);
      if ($urandom_range(7) == 0) low_on = 3'($urandom_range(7));
      if ($urandom_range(63) == 0) ch_mask = 3'($urandom_range(7));
      if ($urandom_range(63) == 0) mode_any = 1'($urandom_range(1));
      if ($urandom_range(31) == 0)
        acq_cycles = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom_range(6, 1));
      adc_busy  = ($urandom_range(3) == 0);
      adc_done  = ($urandom_range(7) == 0);
      clr_flags = ($urandom_range(49) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
